// File: rtl/sbox_byte_sched.sv
//==============================================================================
// Module   : sbox_byte_sched (plus shared sbox)
// Purpose  : Byte-serial SubBytes/InvSubBytes over one shared S-box.
//            Optional macro SBOX_PIPE_EN registers the S-box output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sbox (
    input  logic [7:0] i_data,
    input  logic       i_ctrl,
    output logic [7:0] o_data
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 equals the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_gi;

    // One inverter serves both directions; affine maps sit on either side.
    always_comb begin
        w_pre  = i_ctrl ? aff_inv(i_data) : i_data;
        w_gi   = gf_inv(w_pre);
        o_data = i_ctrl ? w_gi : aff_fwd(w_gi);
    end
endmodule

module sbox_byte_sched #(
    parameter int NBYTES = 16,
    parameter int IDXW   = $clog2(NBYTES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [8*NBYTES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic                  busy,
    output logic [IDXW-1:0]       byte_idx
);
    localparam logic [1:0]      c_IDLE = 2'd0;
    localparam logic [1:0]      c_RUN  = 2'd1;
    localparam logic [1:0]      c_DONE = 2'd2;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(NBYTES - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                r_mode;
    logic [IDXW-1:0]     r_idx;
    logic [8*NBYTES-1:0] r_work;
    logic [8*NBYTES-1:0] r_out;
    logic [8*NBYTES-1:0] w_final;
    logic [7:0]          w_sbox_in;
    logic [7:0]          w_sbox_out;
    logic                w_accept;
    logic                w_wb_en;
    logic [IDXW-1:0]     w_wb_idx;
    logic [7:0]          w_wb_data;
    logic                w_last;

    assign w_accept = in_valid && (r_state == c_IDLE);

    always_comb begin
        w_sbox_in = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) w_sbox_in = r_work[8*i +: 8];
        end
    end

    sbox u_sbox (
        .i_data (w_sbox_in),
        .i_ctrl (r_mode),
        .o_data (w_sbox_out)
    );

`ifdef SBOX_PIPE_EN
    logic [7:0]      r_pipe_data;
    logic [IDXW-1:0] r_pipe_idx;
    logic            r_pipe_vld;
    logic            r_issue_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_data  <= 8'h00;
            r_pipe_idx   <= '0;
            r_pipe_vld   <= 1'b0;
            r_issue_done <= 1'b0;
        end else begin
            r_pipe_data <= w_sbox_out;
            r_pipe_idx  <= r_idx;
            r_pipe_vld  <= (r_state == c_RUN) && !r_issue_done;
            if (w_accept)
                r_issue_done <= 1'b0;
            else if ((r_state == c_RUN) && (r_idx == c_LAST))
                r_issue_done <= 1'b1;
        end
    end

    assign w_wb_en   = r_pipe_vld;
    assign w_wb_idx  = r_pipe_idx;
    assign w_wb_data = r_pipe_data;
    assign w_last    = r_pipe_vld && (r_pipe_idx == c_LAST);
`else
    assign w_wb_en   = (r_state == c_RUN);
    assign w_wb_idx  = r_idx;
    assign w_wb_data = w_sbox_out;
    assign w_last    = (r_state == c_RUN) && (r_idx == c_LAST);
`endif

    // The last byte is merged on the fly so out_data only ever shows whole jobs.
    always_comb begin
        w_final = r_work;
        w_final[8*(NBYTES-1) +: 8] = w_wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_next = c_RUN;
            c_RUN:   if (w_last)    w_next = c_DONE;
            c_DONE:  if (out_ready) w_next = c_IDLE;
            default:                w_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
        busy      = (r_state == c_RUN) || (r_state == c_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 1'b0;
            r_idx  <= '0;
            r_work <= '0;
            r_out  <= '0;
        end else begin
            if (w_accept) begin
                r_work <= in_data;
                r_mode <= in_mode;
                r_idx  <= '0;
            end else if (r_state == c_RUN) begin
                if (w_last)
                    r_idx <= '0;
                else if (r_idx != c_LAST)
                    r_idx <= r_idx + 1'b1;
                // Substituted bytes overwrite their source in place.
                if (w_wb_en) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (w_wb_idx == IDXW'(i)) r_work[8*i +: 8] <= w_wb_data;
                    end
                end
                if (w_last) r_out <= w_final;
            end
        end
    end

    assign out_data = r_out;
    assign byte_idx = r_idx;
endmodule

`default_nettype wire

// File: tb/tb_sbox_byte_sched.sv
// Directed self-checking bench for sbox_byte_sched (16-byte and 2-byte instances).
`default_nettype none

module tb_sbox_byte_sched;
`ifdef SBOX_PIPE_EN
    localparam int LAT16 = 17;
    localparam int LAT2  = 3;
`else
    localparam int LAT16 = 16;
    localparam int LAT2  = 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_mode = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic [3:0]   byte_idx;

    logic         in_valid2 = 1'b0;
    logic         in_mode2 = 1'b0;
    logic [15:0]  in_data2 = '0;
    logic         out_ready2 = 1'b0;
    logic         in_ready2, out_valid2, busy2;
    logic [15:0]  out_data2;
    logic [0:0]   byte_idx2;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    always #5 clk = ~clk;

    sbox_byte_sched #(.NBYTES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .byte_idx(byte_idx)
    );

    sbox_byte_sched #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_mode(in_mode2), .in_data(in_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2), .busy(busy2), .byte_idx(byte_idx2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept one job on dut and wait for out_valid, counting edges.
    task automatic start16(input logic [127:0] data, input logic mode);
        @(negedge clk);
        in_data  = data;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic handshake16(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ov_drop"}, {127'b0, out_valid}, 128'd0);
        check({tag, "_ir_back"}, {127'b0, in_ready}, 128'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_in_ready", {127'b0, in_ready}, 128'd1);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_busy", {127'b0, busy}, 128'd0);
        check("rst_byte_idx", {124'b0, byte_idx}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Encrypt zeros, then stall the consumer for five cycles.
        start16(128'd0, 1'b0);
        check("enc0_latency", 128'(lat), 128'(LAT16));
        check("enc0_data", out_data, {16{8'h63}});
        check("enc0_busy", {127'b0, busy}, 128'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_ov", {127'b0, out_valid}, 128'd1);
            check("stall_ir", {127'b0, in_ready}, 128'd0);
            check("stall_data", out_data, {16{8'h63}});
        end
        handshake16("enc0");
        @(posedge clk);
        #1 check("idle_hold_data", out_data, {16{8'h63}});

        start16({16{8'h63}}, 1'b1);
        check("dec63_data", out_data, 128'd0);
        handshake16("dec63");

        start16({120'd0, 8'h53}, 1'b0);
        check("enc53_data", out_data, {{15{8'h63}}, 8'hED});
        handshake16("enc53");

        start16({{15{8'h63}}, 8'hED}, 1'b1);
        check("dec_roundtrip", out_data, {120'd0, 8'h53});
        handshake16("roundtrip");

        // Inputs churn during RUN; only the accepted job may matter.
        @(negedge clk);
        in_data  = {112'd0, 8'h01, 8'h53};
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        #1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_mode  = ~in_mode;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1 lat++;
        end
        in_valid = 1'b0;
        check("churn_latency", 128'(lat), 128'(LAT16));
        check("churn_data", out_data, {{14{8'h63}}, 8'h7C, 8'hED});
        handshake16("churn");
        @(posedge clk);
        #1;
        check("churn_single_job", {127'b0, busy}, 128'd0);

        // Asynchronous reset while byte 7 is being processed.
        @(negedge clk);
        in_data  = {16{8'hAA}};
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (byte_idx != 4'd7 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("abort_reached_idx7", {124'b0, byte_idx}, 128'd7);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", {127'b0, out_valid}, 128'd0);
        check("abort_busy", {127'b0, busy}, 128'd0);
        check("abort_byte_idx", {124'b0, byte_idx}, 128'd0);
        check("abort_in_ready", {127'b0, in_ready}, 128'd1);
        check("abort_out_data", out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        start16({16{8'hFF}}, 1'b0);
        check("post_rst_latency", 128'(lat), 128'(LAT16));
        check("post_rst_data", out_data, {16{8'h16}});
        handshake16("post_rst");

        // Two-byte instance.
        @(negedge clk);
        in_data2  = 16'hFF01;
        in_mode2  = 1'b0;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        check("n2_idx_first", {127'b0, byte_idx2}, 128'd0);
        check("n2_busy", {127'b0, busy2}, 128'd1);
        @(posedge clk);
        #1;
        lat = 1;
        check("n2_idx_second", {127'b0, byte_idx2}, 128'd1);
        while (!out_valid2 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("n2_latency", 128'(lat), 128'(LAT2));
        check("n2_data", {112'd0, out_data2}, {112'd0, 16'h167C});
        check("n2_idx_done", {127'b0, byte_idx2}, 128'd0);
        @(negedge clk);
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        check("n2_ov_drop", {127'b0, out_valid2}, 128'd0);
        check("n2_ir_back", {127'b0, in_ready2}, 128'd1);
        out_ready2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
